// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that feeds bytes from four requesters into a single
// UART transmitter. Once a requester wins, it keeps ownership until it sends
// a byte marked last, or until the transmitter fails to start.
//
// Ports
//   baud_clk     clock, all logic on the rising edge
//   nrst         synchronous reset, active-high
//   req_valid    per-requester byte-valid
//   req_data     requester bytes, requester i on [8i+7:8i]
//   req_last     marks the final byte of a requester's message
//   req_ready    one-hot combinational accept strobe
//   busy_tx      busy flag from the transmitter
//   tx_en        start request to the transmitter
//   din          byte to the transmitter (registered)
//   grant        one-hot current owner, 0 when nobody owns the channel
//   err_timeout  one-cycle pulse when the transmitter never started
//
// state | meaning
// IDLE  | waiting for a requester and a free transmitter; accept happens here
// START | tx_en high, waiting for busy_tx, bounded by TIMEOUT cycles
// DRAIN | transmitter busy with the byte; wait for busy_tx to fall

module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4
) (
    input  logic              baud_clk,
    input  logic              nrst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              busy_tx,
    output logic              tx_en,
    output logic [7:0]        din,
    output logic [NREQ-1:0]   grant,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic       lock_q, lock_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [7:0] din_q, din_d;
    logic [3:0] cnt_q, cnt_d;

    logic       sel_vld;
    logic [1:0] sel;
    logic [1:0] rr_idx;
    logic       accept;

    // Requester selection. While locked only the owner is eligible; otherwise
    // scan from ptr upward. The loop runs from the far end down so the
    // requester closest to ptr is the one left standing.
    always_comb begin
        sel_vld = 1'b0;
        sel     = ptr_q;
        rr_idx  = ptr_q;
        if (lock_q) begin
            sel     = owner_q;
            sel_vld = req_valid[owner_q];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                rr_idx = ptr_q + 2'(k);
                if (req_valid[rr_idx]) begin
                    sel_vld = 1'b1;
                    sel     = rr_idx;
                end
            end
        end
    end

    // A byte is only taken in IDLE with the transmitter free and out of reset.
    assign accept = (state_q == S_IDLE) && !busy_tx && sel_vld && !nrst;

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            din_q   <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            err_q   <= err_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        last_d  = last_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    din_d   = req_data[{sel, 3'b000} +: 8];
                    last_d  = req_last[sel];
                    owner_d = sel;
                    lock_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (busy_tx) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    // Transmitter never started: drop the byte and release
                    // the channel so one stuck requester cannot starve others.
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    ptr_d   = owner_q + 2'd1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (!busy_tx) begin
                    state_d = S_IDLE;
                    if (last_q) begin
                        lock_d = 1'b0;
                        ptr_d  = owner_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        grant     = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
        if (lock_q) begin
            grant[owner_q] = 1'b1;
        end
    end

    assign tx_en       = (state_q == S_START);
    assign din         = din_q;
    assign err_timeout = err_q;

endmodule
